nbit_serial_transmitter: RTL
============================

// Module: nbit_serial_transmitter
// PURPOSE
//   Parallel-in/serial-out word transmitter; transmit end of the serial link whose receive end is the
//   N-bit shift register (serial in Ds, shiftL/shiftR enables). Accepts N-bit words on valid/ready,
//   emits one bit per clk on ser_out plus a matching shiftL/shiftR strobe to wire straight to the
//   receiver; after N strobes the receiver's Q equals the accepted word.
// PARAMETERS
//   N    4  word width in bits (N >= 2)
//   GAP  1  idle cycles between the last bit of one word and the next in_ready (0..15)
// PORTS
//   clk        in   1  clock, all state changes on posedge
//   clr        in   1  asynchronous active-low reset; acts on negedge clr, no clock needed
//   in_data    in   N  parallel word to send
//   in_msb     in   1  1 = MSB first (drives shiftL), 0 = LSB first (drives shiftR); sampled at accept
//   in_valid   in   1  word available
//   in_ready   out  1  block idle, can accept this cycle
//   ser_out    out  1  serial bit, to receiver Ds
//   shiftL     out  1  receiver shift-left strobe, high while an MSB-first bit is on ser_out
//   shiftR     out  1  receiver shift-right strobe, high while an LSB-first bit is on ser_out
//   busy       out  1  high from accept until return to IDLE (includes GAP)
//   done       out  1  one-cycle pulse coincident with the last bit of a frame
// BEHAVIOUR
// - All outputs registered. clr=0: state IDLE, shift reg/counters 0, all outputs 0 (in_ready also 0).
//   First posedge after clr release sets in_ready=1.
// - FSM IDLE -> SHIFT -> GAP -> IDLE (GAP state skipped when GAP=0).
//   IDLE: in_ready=1. Accept on posedge when in_valid&in_ready; load in_data, latch in_msb, bit count 0,
//   in_ready->0, busy->1, enter SHIFT. in_valid without in_ready has no effect; in_data need not hold.
//   SHIFT: accept edge k -> bits on ser_out in cycles k+1..k+N, one per cycle, MSB-first = D[N-1]..D[0],
//   LSB-first = D[0]..D[N-1]. Exactly one of shiftL/shiftR high in each bit cycle, both low otherwise.
//   done=1 in cycle k+N only. Count width $clog2(N+1); no wrap within a frame.
//   GAP: ser_out=0, strobes 0, busy=1 for GAP cycles; then IDLE with in_ready=1 at cycle k+N+GAP+1.
// - in_valid held high continuously: next word accepted on the first edge in_ready=1; frame period N+GAP+1.
// - Receiver timing: receiver samples Ds on the edge ending each bit cycle, so its Q holds the word
//   after edge k+N+1.
// - Reset mid-frame: all outputs to 0 asynchronously, frame discarded (done never pulses),
//   restart from IDLE as above.
// - in_msb change during a frame ignored. ser_out idle level is 0.
// CONFIGURATION
//   SER_TX_PARITY_EN defined: one extra even-parity bit (^word) follows the data bits, with the same
//   strobe direction; frame = N+1 bit cycles, done moves to the parity cycle (k+N+1), period N+GAP+2.
//   Receiver must then be N+1 bits wide. Undefined: no parity bit, frame = N bit cycles, as above.
// TESTING (N=4, GAP=1 unless noted; macro undefined unless noted)
// - Hold clr=0 with in_valid=1 -> all outputs 0, no accept; release -> in_ready=1 after first edge.
// - in_data=4'b1011,in_msb=1 -> ser_out 1,0,1,1 with shiftL=1 x4, shiftR=0, done on 4th; receiver Q=4'b1011.
// - in_data=4'b1011,in_msb=0 -> ser_out 1,1,0,1 with shiftR=1 x4; done on 4th; receiver Q=4'b1011.
// - in_valid held high, words 4'hA then 4'h5 -> second accept exactly 6 cycles after first; 1 idle gap cycle.
// - clr pulsed low during 2nd bit of 4'hF -> outputs 0 at once, no done; next word 4'h3 sent intact.
// - SER_TX_PARITY_EN defined, in_data=4'b0111,in_msb=1 -> ser_out 0,1,1,1,1; done on 5th bit.

Source files
------------

// File: rtl/nbit_serial_transmitter.sv
// Parallel-in/serial-out word transmitter with receiver shift strobes and valid/ready intake.
// Optional SER_TX_PARITY_EN appends an even-parity bit after the data bits.
module nbit_serial_transmitter #(
    parameter int N   = 4,
    parameter int GAP = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] in_data,
    input  logic         in_msb,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         ser_out,
    output logic         shiftL,
    output logic         shiftR,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N + 1);
`ifdef SER_TX_PARITY_EN
    localparam int NBITS = N + 1;
`else
    localparam int NBITS = N;
`endif
    localparam logic [CW-1:0] LAST    = CW'(NBITS - 1);
    localparam logic [CW-1:0] PRELAST = CW'(NBITS - 2);
    localparam logic [3:0]    GAPV    = 4'(GAP);

    typedef enum logic [1:0] {IDLE, SHIFT, GAPS} state_t;

    state_t        state;
    logic [N-1:0]  sreg;
    logic          msb;
    logic [CW-1:0] cnt;
    logic [3:0]    gcnt;
    logic          nxt_bit;
`ifdef SER_TX_PARITY_EN
    logic          par;
`endif

    function automatic logic head_bit(input logic [N-1:0] w, input logic m);
        return m ? w[N-1] : w[0];
    endfunction

    function automatic logic [N-1:0] advance(input logic [N-1:0] w, input logic m);
        return m ? {w[N-2:0], 1'b0} : {1'b0, w[N-1:1]};
    endfunction

    // cnt is the index of the bit currently on ser_out; the parity bit follows index N-1
    always_comb begin
        nxt_bit = head_bit(sreg, msb);
`ifdef SER_TX_PARITY_EN
        if (cnt == PRELAST)
            nxt_bit = par;
`endif
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            sreg     <= '0;
            msb      <= 1'b0;
            cnt      <= '0;
            gcnt     <= '0;
            in_ready <= 1'b0;
            ser_out  <= 1'b0;
            shiftL   <= 1'b0;
            shiftR   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SER_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready && in_valid) begin
                        // first bit goes out in the cycle right after the accept edge
                        sreg     <= advance(in_data, in_msb);
                        msb      <= in_msb;
                        cnt      <= '0;
                        ser_out  <= head_bit(in_data, in_msb);
                        shiftL   <= in_msb;
                        shiftR   <= !in_msb;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef SER_TX_PARITY_EN
                        par      <= ^in_data;
`endif
                        state    <= SHIFT;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        ser_out <= 1'b0;
                        shiftL  <= 1'b0;
                        shiftR  <= 1'b0;
                        done    <= 1'b0;
                        if (GAP == 0) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                        end else begin
                            state <= GAPS;
                            gcnt  <= 4'd1;
                        end
                    end else begin
                        cnt     <= cnt + 1'b1;
                        ser_out <= nxt_bit;
                        sreg    <= advance(sreg, msb);
                        done    <= (cnt == PRELAST);
                    end
                end
                GAPS: begin
                    if (gcnt == GAPV) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        gcnt     <= '0;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
